// File: rtl/ahb_split_slave_if.sv
// AHB-Lite bus bundle for the split-capable slave: address/data phase signals
// from the master side plus the slave response and the HSPLIT vector to the arbiter.
interface ahb_split_slave_if;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [3:0]  HMASTER;
    logic        HREADY;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
    logic [15:0] HSPLIT;

    modport slave (
        input  HSEL, HTRANS, HWRITE, HADDR, HWDATA, HMASTER, HREADY,
        output HREADYOUT, HRESP, HRDATA, HSPLIT
    );

    modport master (
        output HSEL, HTRANS, HWRITE, HADDR, HWDATA, HMASTER, HREADY,
        input  HREADYOUT, HRESP, HRDATA, HSPLIT
    );
endinterface

// File: rtl/ahb_split_slave.sv
// AHB-Lite slave that always splits reads, fetches the word over LATENCY cycles,
// then un-splits the owner via HSPLIT; contending masters are released in bulk.
module ahb_split_slave #(
    parameter int DEPTH   = 16,
    parameter int LATENCY = 4
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_split_slave_if.slave   io_bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Load value covers the two split-response cycles before LATENCY starts counting.
    localparam logic [4:0] CNT_LOAD = 5'(LATENCY + 2);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_VALID, ST_RELEASE} state_t;
    typedef enum logic [1:0] {RSP_OKAY, RSP_SPLIT1, RSP_SPLIT2} rsp_t;

    state_t         r_state;
    logic [4:0]     r_cnt;
    logic [3:0]     r_owner;
    logic [AW-1:0]  r_addr;
    logic [15:0]    r_pending;
    logic [31:0]    r_buffer;
    rsp_t           r_rsp;
    logic [31:0]    r_hrdata;
    logic [15:0]    r_hsplit;
    logic           r_wr_pend;
    logic [AW-1:0]  r_wr_addr;
    logic [31:0]    r_mem [DEPTH];

    state_t         w_state_next;
    logic [4:0]     w_cnt_next;
    logic [3:0]     w_owner_next;
    logic [AW-1:0]  w_addr_next;
    logic [15:0]    w_pending_next;
    logic           w_capture;
    rsp_t           w_rsp_next;
    logic [31:0]    w_hrdata_next;
    logic [15:0]    w_hsplit_next;

    logic           w_accept;
    logic           w_rd;
    logic           w_wr;
    logic [AW-1:0]  w_idx;
    logic           w_start;
    logic           w_serve;
    logic           w_defer;
    logic           w_mem_we;
    logic           w_unused;

    assign w_accept = io_bus.HSEL & io_bus.HTRANS[1] & io_bus.HREADY;
    assign w_rd     = w_accept & ~io_bus.HWRITE;
    assign w_wr     = w_accept &  io_bus.HWRITE;
    assign w_idx    = io_bus.HADDR[AW+1:2];
    assign w_start  = w_rd & ((r_state == ST_IDLE) | (r_state == ST_RELEASE));
    assign w_serve  = w_rd & (r_state == ST_VALID) &
                      (io_bus.HMASTER == r_owner) & (w_idx == r_addr);
    assign w_defer  = w_rd & ~w_start & ~w_serve;
    assign w_mem_we = r_wr_pend & io_bus.HREADY;
    assign w_unused = ^{io_bus.HADDR, io_bus.HTRANS[0]};

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_owner   <= '0;
            r_addr    <= '0;
            r_pending <= '0;
            r_buffer  <= '0;
            r_rsp     <= RSP_OKAY;
            r_hrdata  <= '0;
            r_hsplit  <= '0;
            r_wr_pend <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_owner   <= w_owner_next;
            r_addr    <= w_addr_next;
            r_pending <= w_pending_next;
            r_rsp     <= w_rsp_next;
            r_hrdata  <= w_hrdata_next;
            r_hsplit  <= w_hsplit_next;
            if (w_capture) r_buffer <= r_mem[r_addr];
            if (io_bus.HREADY) r_wr_pend <= w_wr;
            if (w_wr) r_wr_addr <= w_idx;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_mem_we) begin
            r_mem[r_wr_addr] <= io_bus.HWDATA;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_owner_next   = r_owner;
        w_addr_next    = r_addr;
        w_pending_next = r_pending;
        w_capture      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_cnt_next = r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    w_state_next = ST_VALID;
                    w_capture    = 1'b1;
                end
            end
            ST_VALID: begin
                if (w_serve) begin
                    w_state_next   = ST_RELEASE;
                    w_pending_next = '0;
                end
            end
            ST_RELEASE: w_state_next = ST_IDLE;
            default:    w_state_next = r_state;
        endcase
        if (w_start) begin
            w_state_next = ST_FETCH;
            w_cnt_next   = CNT_LOAD;
            w_owner_next = io_bus.HMASTER;
            w_addr_next  = w_idx;
        end
        // The owner already holds its own un-split; it never joins the bulk release.
        if (w_defer && (io_bus.HMASTER != r_owner))
            w_pending_next[io_bus.HMASTER] = 1'b1;
    end

    // Output logic (next values of the registered bus outputs)
    always_comb begin
        w_rsp_next    = RSP_OKAY;
        w_hrdata_next = '0;
        w_hsplit_next = '0;
        if (r_rsp == RSP_SPLIT1)
            w_rsp_next = RSP_SPLIT2;
        else if (w_start || w_defer)
            w_rsp_next = RSP_SPLIT1;
        if (w_serve)
            w_hrdata_next = r_buffer;
        if (w_capture)
            w_hsplit_next = 16'(1) << r_owner;
        else if (w_serve)
            w_hsplit_next = r_pending;
    end

    assign io_bus.HREADYOUT = (r_rsp != RSP_SPLIT1);
    assign io_bus.HRESP     = (r_rsp == RSP_OKAY) ? 2'b00 : 2'b11;
    assign io_bus.HRDATA    = r_hrdata;
    assign io_bus.HSPLIT    = r_hsplit;
endmodule

// File: doc/ahb_split_slave.md
Name: ahb_split_slave

Overview:
- AHB-Lite style slave with SPLIT capability. It sits directly upstream of the bus arbiter and drives the arbiter's 16-bit HSPLIT input.
- Read transfers are never served immediately. The slave splits the requesting master, fetches the word over LATENCY cycles, then un-splits that master through HSPLIT so it can retry and collect the data.
- Masters that arrive while the fetch engine is occupied are also split. They are recorded in a pending mask and released in bulk when the engine frees up.
- Backing store is a DEPTH-word register file. Writes complete with zero wait states.

Parameters:
- DEPTH, 16, number of 32-bit words in the register file (power of two, 2..256)
- LATENCY, 4, fetch cycles from end of SPLIT response to data-valid (1..15)

Ports:
- HCLK  input  1  bus clock, all logic on rising edge
- HRESET  input  1  synchronous, active-high reset
- HSEL  input  1  slave select (address phase)
- HTRANS  input  2  transfer type; NONSEQ=2'b10 and SEQ=2'b11 are active
- HWRITE  input  1  1 = write (address phase)
- HADDR  input  32  byte address; word index = HADDR[log2(DEPTH)+1:2]
- HWDATA  input  32  write data (data phase)
- HMASTER  input  4  current address-phase master number, from the arbiter
- HREADY  input  1  bus-wide ready
- HREADYOUT  output  1  slave ready
- HRESP  output  2  OKAY=2'b00, SPLIT=2'b11
- HRDATA  output  32  read data
- HSPLIT  output  16  one-cycle un-split pulses, one bit per master

Behaviour:
- Reset, when HRESET=1 at a clock edge:
  - HREADYOUT=1, HRESP=OKAY, HRDATA=0, HSPLIT=0.
  - Engine returns to IDLE; pending mask, counter and buffer are cleared.
  - Register file is cleared to 0.
  - Reset mid-fetch or mid-response aborts everything, with no HSPLIT pulse.
- Transfer acceptance: a transfer is accepted when HSEL & HTRANS[1] & HREADY at a clock edge. HADDR, HWRITE and HMASTER are sampled at that edge.
- Writes: always zero-wait.
  - Next cycle: HREADYOUT=1, HRESP=OKAY.
  - HWDATA is written to the sampled word index at the end of that data phase.
  - Engine state is not affected.
- Read transfers are resolved by engine state:
  - IDLE: latch owner=HMASTER and addr=word index, then issue a two-cycle SPLIT.
    - Cycle 1: HREADYOUT=0, HRESP=SPLIT.
    - Cycle 2: HREADYOUT=1, HRESP=SPLIT.
    - Engine enters FETCH with counter=LATENCY.
  - FETCH: decrement the counter each cycle. At 0, capture mem[addr] into the buffer and go to VALID. In the same cycle HSPLIT[owner]=1 for exactly one cycle.
  - VALID, with HMASTER==owner and the word index matching addr: zero-wait OKAY; HRDATA=buffer in the data phase.
    - Engine goes to RELEASE (one cycle), then IDLE.
    - If the pending mask is non-zero, HSPLIT=pending for the single RELEASE cycle, and the mask is cleared.
  - Any other read (engine in FETCH, or VALID with a different master or address): two-cycle SPLIT as above, and pending[HMASTER] is set.
  - A read arriving during RELEASE is treated as the IDLE case.
- Owner retry with a wrong address while VALID: split as a pending master. The owner stays owner and keeps the buffer.
- A write to addr while the engine is VALID does not update the buffer, which still holds fetch-time data.
- Pending mask:
  - A bit set in the same cycle RELEASE pulses is kept and pulsed at the next RELEASE.
  - The owner bit is never set in the pending mask while it is the owner.
- HSPLIT is a registered output; it is never asserted outside the FETCH→VALID cycle and the RELEASE cycle.
- IDLE transfers (HTRANS=00) and BUSY transfers (01), and unselected cycles, give HREADYOUT=1, HRESP=OKAY, with no state change.
- HRDATA=0 whenever the data phase is not an OKAY read.

Test Plan:
- Write then read: write 0xDEADBEEF to 0x08 by master 2 → OKAY, zero wait.
  - Read 0x08 by master 2 → two-cycle SPLIT: HREADYOUT 0 then 1, HRESP=11.
  - LATENCY=4 cycles later HSPLIT=0x0004 for one cycle.
  - Retry → OKAY with HRDATA=0xDEADBEEF; HSPLIT stays 0 at release.
- Contention: master 2 fetching 0x08; masters 5 and 9 read during FETCH → each gets a two-cycle SPLIT.
  - Owner completes its retry → HSPLIT=0x0220 for exactly one cycle in RELEASE.
- Wrong requester while VALID: master 7 reads 0x08 → SPLIT, pending bit 7 set.
  - Master 2 retry still returns data; RELEASE pulses 0x0080.
- Reset mid-FETCH: HRESET=1 at counter=2 → next cycle HSPLIT=0, HREADYOUT=1, HRESP=00.
  - Read of 0x08 returns 0 after a fresh split/fetch.
- Non-active transfers: HTRANS=00 or 01 with HSEL=1, and HSEL=0 with HTRANS=10 → HREADYOUT=1, HRESP=00, engine unchanged.
- Write-after-fetch: master 3 fetch 0x04 (value 0x11) reaches VALID; write 0x22 to 0x04 → retry returns 0x11.
  - A fresh read afterwards returns 0x22.
